// File: rtl/apb_pkg.sv
// Shared request/state types for the APB requester; types only, no latency, no flow control.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int STRB_W     = APB_DATA_W / 8;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [STRB_W-1:0]     strb;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

endpackage

// File: rtl/apb_req_fifo.sv
// Request FIFO; an entry becomes poppable two edges after its push (one-cycle visibility lag).
// Backpressure: full reflects every stored entry, so a same-cycle pop never frees a slot early.
module apb_req_fifo
    import apb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     PCLK,
    input  logic     PRESET,
    input  logic     push_vld,
    input  apb_req_t push_dat,
    input  logic     pop_vld,
    output apb_req_t pop_dat,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    apb_req_t       mem [DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] wr_ptr_vis;
    logic [PTR_W:0] rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push_vld && !full;
    assign do_pop  = pop_vld && !empty;

    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    // empty compares against the lagged write pointer so the consumer sees new entries one cycle late
    assign empty   = (wr_ptr_vis == rd_ptr);
    assign pop_dat = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr     <= '0;
            wr_ptr_vis <= '0;
            rd_ptr     <= '0;
        end else begin
            wr_ptr_vis <= wr_ptr;
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/apb_req_master.sv
// APB4 requester: one transfer in flight, handshake->PSEL 2 cycles, ->rsp 4 cycles plus wait states.
// Backpressure: req_ready drops when the FIFO is full; no new transfer starts while a response is unaccepted.
module apb_req_master
    import apb_pkg::*;
#(
    parameter int ADDR_W    = APB_ADDR_W,
    parameter int DATA_W    = APB_DATA_W,
    parameter int REQ_DEPTH = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W/8-1:0] req_strb,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W/8-1:0] PSTRB,
    output logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                psel_d, penable_d, pwrite_d;
    logic [ADDR_W-1:0]   paddr_d;
    logic [DATA_W/8-1:0] pstrb_d;
    logic [DATA_W-1:0]   pwdata_d;
    logic                rsp_valid_d, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_d;

    apb_req_t            fifo_in;
    apb_req_t            fifo_out;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;

    assign fifo_in   = '{write: req_write, addr: req_addr, strb: req_strb, wdata: req_wdata};
    assign req_ready = !fifo_full;

    apb_req_fifo #(
        .DEPTH (REQ_DEPTH)
    ) u_fifo (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .push_vld (req_valid && req_ready),
        .push_dat (fifo_in),
        .pop_vld  (fifo_pop),
        .pop_dat  (fifo_out),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        psel_d      = PSEL;
        penable_d   = PENABLE;
        pwrite_d    = PWRITE;
        paddr_d     = PADDR;
        pstrb_d     = PSTRB;
        pwdata_d    = PWDATA;
        rsp_valid_d = rsp_valid;
        rsp_err_d   = rsp_err;
        rsp_rdata_d = rsp_rdata;
        fifo_pop    = 1'b0;

        if (rsp_valid && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // the response slot must be free (or freeing now) so a finished transfer always has a home
                if (!fifo_empty && (!rsp_valid || rsp_ready)) begin
                    fifo_pop  = 1'b1;
                    paddr_d   = fifo_out.addr;
                    pwrite_d  = fifo_out.write;
                    pwdata_d  = fifo_out.wdata;
                    pstrb_d   = fifo_out.write ? fifo_out.strb : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = PWRITE ? '0 : PRDATA;
                    state_d     = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PSTRB     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            PWRITE    <= pwrite_d;
            PADDR     <= paddr_d;
            PSTRB     <= pstrb_d;
            PWDATA    <= pwdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master with a behavioural APB slave whose wait states are set per test.
module tb_apb_req_master;

    logic        PCLK;
    logic        PRESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_strb;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [3:0]  PSTRB;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    int          errors;
    int          checks;
    int          slv_wait;
    logic [31:0] slv_rdata;
    logic        slv_xor;
    int          acc_n;

    apb_req_master #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .REQ_DEPTH (2),
        .TIMEOUT   (16)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_strb  (req_strb),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PSTRB     (PSTRB),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // slave: PREADY rises after slv_wait ACCESS cycles; PRDATA optionally tagged with the address
    initial begin
        acc_n  = 0;
        PREADY = 1'b0;
        PRDATA = '0;
        forever begin
            @(posedge PCLK);
            #1;
            if (PSEL && PENABLE) begin
                PREADY = (acc_n >= slv_wait);
                acc_n++;
            end else begin
                PREADY = 1'b0;
                acc_n  = 0;
            end
            PRDATA = slv_xor ? (slv_rdata ^ PADDR) : slv_rdata;
        end
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic push(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_strb  = s;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        tick();
        tick();
        checks++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err});
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready: got %b expected 1", req_ready);
        end
        checks++;
        if ({PADDR, PSTRB, PWDATA, rsp_rdata} !== 100'b0) begin
            errors++;
            $display("FAIL reset_buses: got %h expected 0", {PADDR, PSTRB, PWDATA, rsp_rdata});
        end
        PRESET = 1'b0;
        tick();
    endtask

    task automatic test_write_zero_wait();
        rsp_ready = 1'b1;
        slv_wait  = 0;
        push(1'b1, 32'h0, 4'hF, 32'h0005_0003);
        tick();
        checks++;
        if (PSEL !== 1'b0) begin
            errors++;
            $display("FAIL wr_psel_early: got %b expected 0", PSEL);
        end
        tick();
        checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA} !== {3'b101, 32'h0, 4'hF, 32'h0005_0003}) begin
            errors++;
            $display("FAIL wr_setup: got %h expected %h", {PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA},
                     {3'b101, 32'h0, 4'hF, 32'h0005_0003});
        end
        tick();
        checks++;
        if ({PSEL, PENABLE, rsp_valid, PSTRB, PWDATA} !== {3'b110, 4'hF, 32'h0005_0003}) begin
            errors++;
            $display("FAIL wr_access: got %h expected %h", {PSEL, PENABLE, rsp_valid, PSTRB, PWDATA},
                     {3'b110, 4'hF, 32'h0005_0003});
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE} !== {2'b10, 32'h0, 2'b00}) begin
            errors++;
            $display("FAIL wr_rsp: got %h expected %h", {rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE},
                     {2'b10, 32'h0, 2'b00});
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_rsp_clear: got %b expected 0", rsp_valid);
        end
    endtask

    task automatic test_read_wait();
        int lat;
        int pen;
        int strb_bad;
        lat       = 0;
        pen       = 0;
        strb_bad  = 0;
        slv_wait  = 2;
        slv_rdata = 32'h0001_0000;
        push(1'b0, 32'h4, 4'hF, 32'h1234_5678);
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            tick();
            if (PENABLE) pen++;
            if (PSEL && PSTRB !== 4'h0) strb_bad++;
            if (rsp_valid) lat = k;
        end
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL rd_latency: got %0d expected 6", lat);
        end
        checks++;
        if (pen !== 3) begin
            errors++;
            $display("FAIL rd_penable_cycles: got %0d expected 3", pen);
        end
        checks++;
        if (strb_bad !== 0) begin
            errors++;
            $display("FAIL rd_pstrb_zero: got %0d bad cycles expected 0", strb_bad);
        end
        checks++;
        if ({rsp_err, rsp_rdata} !== {1'b0, 32'h0001_0000}) begin
            errors++;
            $display("FAIL rd_rsp: got %h expected %h", {rsp_err, rsp_rdata}, {1'b0, 32'h0001_0000});
        end
        tick();
    endtask

    task automatic test_unaligned();
        int   acc;
        int   paddr_bad;
        int   rsp_cnt;
        logic err_seen;
        logic [31:0] rdata_seen;
        acc        = 0;
        paddr_bad  = 0;
        rsp_cnt    = 0;
        err_seen   = 1'bx;
        rdata_seen = 'x;
        slv_wait   = 1;
        slv_rdata  = 32'hFFFF_FFFF;
        push(1'b1, 32'h1, 4'hF, 32'hA5A5_1234);
        for (int k = 0; k < 16; k++) begin
            tick();
            if (PSEL && PENABLE) acc++;
            if (PSEL && PADDR !== 32'h1) paddr_bad++;
            if (rsp_valid) begin
                rsp_cnt++;
                err_seen   = rsp_err;
                rdata_seen = rsp_rdata;
            end
        end
        checks++;
        if (acc !== 2 || paddr_bad !== 0) begin
            errors++;
            $display("FAIL ua_access: got acc=%0d paddr_bad=%0d expected acc=2 paddr_bad=0", acc, paddr_bad);
        end
        checks++;
        if (rsp_cnt !== 1) begin
            errors++;
            $display("FAIL ua_rsp_count: got %0d expected 1", rsp_cnt);
        end
        checks++;
        if ({err_seen, rdata_seen} !== 33'h0) begin
            errors++;
            $display("FAIL ua_rsp: got %h expected 0", {err_seen, rdata_seen});
        end
    endtask

    task automatic test_timeout();
        int acc;
        int found;
        acc       = 0;
        found     = 0;
        slv_wait  = 1000;
        slv_rdata = 32'hDEAD_BEEF;
        push(1'b0, 32'h8, 4'hF, 32'h0);
        push(1'b0, 32'hC, 4'hF, 32'h0);
        for (int k = 0; k < 60 && found == 0; k++) begin
            tick();
            if (PSEL && PENABLE) acc++;
            if (rsp_valid) found = 1;
        end
        checks++;
        if (acc !== 16) begin
            errors++;
            $display("FAIL to_access_cycles: got %0d expected 16", acc);
        end
        checks++;
        if ({found[0], rsp_err, rsp_rdata, PSEL} !== {2'b11, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL to_rsp: got %h expected %h", {found[0], rsp_err, rsp_rdata, PSEL}, {2'b11, 32'h0, 1'b0});
        end
        slv_wait = 0;
        tick();
        checks++;
        if ({PSEL, PENABLE, rsp_valid, PADDR} !== {3'b100, 32'hC}) begin
            errors++;
            $display("FAIL to_next_setup: got %h expected %h", {PSEL, PENABLE, rsp_valid, PADDR}, {3'b100, 32'hC});
        end
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            tick();
            if (rsp_valid) found = 1;
        end
        checks++;
        if ({found[0], rsp_err, rsp_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL to_next_rsp: got %h expected %h", {found[0], rsp_err, rsp_rdata}, {2'b10, 32'hDEAD_BEEF});
        end
        tick();
    endtask

    task automatic test_back_pressure();
        int found;
        int psel_seen;
        int hold_bad;
        int n;
        logic [31:0] got [4];
        found     = 0;
        psel_seen = 0;
        hold_bad  = 0;
        n         = 0;
        rsp_ready = 1'b0;
        slv_wait  = 0;
        slv_xor   = 1'b1;
        slv_rdata = 32'h5000_0000;
        push(1'b1, 32'h10, 4'hF, 32'h1);
        for (int k = 0; k < 20 && found == 0; k++) begin
            tick();
            if (rsp_valid) found = 1;
        end
        checks++;
        if (found !== 1) begin
            errors++;
            $display("FAIL bp_first_rsp: got %0d expected 1", found);
        end
        push(1'b0, 32'h14, 4'hF, 32'h0);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_one: got %b expected 1", req_ready);
        end
        push(1'b0, 32'h18, 4'hF, 32'h0);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_full: got %b expected 0", req_ready);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            if (PSEL) psel_seen++;
            if (!rsp_valid || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) hold_bad++;
        end
        checks++;
        if (psel_seen !== 0 || hold_bad !== 0) begin
            errors++;
            $display("FAIL bp_hold: got psel=%0d hold_bad=%0d expected 0 and 0", psel_seen, hold_bad);
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (rsp_valid && n < 4) begin
                got[n] = rsp_rdata;
                n++;
            end
        end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL bp_rsp_count: got %0d expected 2", n);
        end
        checks++;
        if (n < 2 || got[0] !== 32'h5000_0014 || got[1] !== 32'h5000_0018) begin
            errors++;
            $display("FAIL bp_order: got %h %h expected 50000014 50000018", got[0], got[1]);
        end
        slv_xor = 1'b0;
    endtask

    task automatic test_reset_mid();
        int found;
        int act;
        found    = 0;
        act      = 0;
        slv_wait = 1000;
        push(1'b0, 32'h20, 4'hF, 32'h0);
        push(1'b0, 32'h24, 4'hF, 32'h0);
        for (int k = 0; k < 20 && found == 0; k++) begin
            tick();
            if (PSEL && PENABLE) found = 1;
        end
        tick();
        tick();
        PRESET = 1'b1;
        tick();
        checks++;
        if ({found[0], PSEL, PENABLE, rsp_valid, req_ready} !== 5'b10001) begin
            errors++;
            $display("FAIL rst_mid: got %b expected 10001", {found[0], PSEL, PENABLE, rsp_valid, req_ready});
        end
        PRESET   = 1'b0;
        slv_wait = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (PSEL || rsp_valid) act++;
        end
        checks++;
        if (act !== 0) begin
            errors++;
            $display("FAIL rst_fifo_empty: got %0d active cycles expected 0", act);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        slv_wait  = 0;
        slv_rdata = '0;
        slv_xor   = 1'b0;
        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_strb  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_unaligned();
        test_timeout();
        test_back_pressure();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
